// File: rtl/button_defs.sv
// Shared button register definitions, also mirrored by CPU-side software constants.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package button_defs;

  localparam int          NUM_BUTTONS        = 4;
  localparam logic [15:0] BTN_DEFAULT_PERIOD = 16'd50000;  // 2 ms at 25 MHz

  // Register offsets relative to BASE_INDEX
  localparam logic [1:0] REG_OFF_STATE   = 2'd0;
  localparam logic [1:0] REG_OFF_PRESS   = 2'd1;
  localparam logic [1:0] REG_OFF_RELEASE = 2'd2;
  localparam logic [1:0] REG_OFF_PERIOD  = 2'd3;

  // Decoded register access
  typedef struct packed {
    logic       hit;
    logic [1:0] off;
  } reg_dec_t;

  // A programmed period of 0 behaves as 1 so a transition still needs one count.
  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button synchronizer and debouncer producing a stable level and edge pulses.
// Latency: 2 sync cycles plus max(period,1) cycles of a steady level before stable toggles.
// Backpressure: none; pulses are single-cycle and must be captured by the caller.
//
// Ports: clk, reset_n (async active-low), btn_raw (async level), period (debounce count),
//        stable (debounced level), rise_pls / fall_pls (one-cycle, coincident with stable change).
module button_debounce
  import button_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_raw,
  input  logic [15:0] period,
  output logic        stable,
  output logic        rise_pls,
  output logic        fall_pls
);

  logic        sync0_q, sync1_q;
  logic        stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        fire;

  // The compare is ">=" so a counter left above a freshly shortened period
  // fires on its next increment rather than wrapping around.
  always_comb begin
    cnt_inc  = {1'b0, cnt_q} + 17'd1;
    fire     = 1'b0;
    cnt_d    = 16'd0;
    stable_d = stable_q;
    if (sync1_q != stable_q) begin
      if (cnt_inc >= {1'b0, eff_period(period)}) begin
        fire     = 1'b1;
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_inc[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      sync0_q  <= btn_raw;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable   = stable_q;
  assign rise_pls = fire & ~stable_q;
  assign fall_pls = fire &  stable_q;

endmodule

// File: rtl/button_controller.sv
// Four debounced buttons behind a CPU register window (STATE, PRESS, RELEASE, PERIOD).
// Latency: read data registered one cycle after register_read; PERIOD writes apply next cycle.
// Backpressure: none; read/write strobes are accepted every cycle.
//
// Ports: clk, reset_n (async active-low), buttons[3:0] (raw, 1=pressed),
//        register_index/read/write/write_value (CPU access), register_read_value
//        (registered, 0 outside window), press_pending (registered OR of PRESS latch).
module button_controller
  import button_defs::*;
#(
  parameter logic [11:0] BASE_INDEX     = 12'd0,
  parameter logic [15:0] DEFAULT_PERIOD = BTN_DEFAULT_PERIOD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  buttons,
  input  logic [11:0] register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        press_pending
);

  logic [3:0]  stable, rise, fall;
  logic [3:0]  press_q, press_d, release_q, release_d;
  logic [3:0]  press_clr, release_clr;
  logic [15:0] period_q, period_d;
  logic [15:0] rdata_q, rdata_d, rd_val;
  logic        pend_q, pend_d;
  logic [12:0] idx_ext, base_ext;
  reg_dec_t    dec;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (buttons[i]),
      .period   (period_q),
      .stable   (stable[i]),
      .rise_pls (rise[i]),
      .fall_pls (fall[i])
    );
  end

  // Decode in 13 bits so a base near the top of the index space cannot wrap.
  always_comb begin
    idx_ext  = {1'b0, register_index};
    base_ext = {1'b0, BASE_INDEX};
    dec.hit  = (idx_ext >= base_ext) && (idx_ext <= base_ext + 13'd3);
    dec.off  = register_index[1:0] - BASE_INDEX[1:0];
  end

  always_comb begin
    rd_val = 16'd0;
    if (dec.hit) begin
      case (dec.off)
        REG_OFF_STATE:   rd_val = {12'd0, stable};
        REG_OFF_PRESS:   rd_val = {12'd0, press_q};
        REG_OFF_RELEASE: rd_val = {12'd0, release_q};
        REG_OFF_PERIOD:  rd_val = period_q;
        default:         rd_val = 16'd0;
      endcase
    end
  end

  // Clear-on-read and write-1-to-clear merge into one mask; new events win.
  always_comb begin
    press_clr   = 4'd0;
    release_clr = 4'd0;
    period_d    = period_q;
    if (dec.hit && register_read) begin
      if (dec.off == REG_OFF_PRESS)   press_clr   = 4'hF;
      if (dec.off == REG_OFF_RELEASE) release_clr = 4'hF;
    end
    if (dec.hit && register_write) begin
      if (dec.off == REG_OFF_PRESS)   press_clr   = press_clr   | register_write_value[3:0];
      if (dec.off == REG_OFF_RELEASE) release_clr = release_clr | register_write_value[3:0];
      if (dec.off == REG_OFF_PERIOD)  period_d    = register_write_value;
    end
    press_d   = (press_q   & ~press_clr)   | rise;
    release_d = (release_q & ~release_clr) | fall;
    rdata_d   = register_read ? rd_val : rdata_q;
    pend_d    = |press_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= 4'd0;
      release_q <= 4'd0;
      period_q  <= DEFAULT_PERIOD;
      rdata_q   <= 16'd0;
      pend_q    <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      period_q  <= period_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_d;
    end
  end

  assign register_read_value = rdata_q;
  assign press_pending       = pend_q;

endmodule

// File: tb/tb_button_controller.sv
// Directed bench for button_controller with BASE_INDEX = 12'h010.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_controller;

  localparam logic [11:0] A_STATE   = 12'h010;
  localparam logic [11:0] A_PRESS   = 12'h011;
  localparam logic [11:0] A_RELEASE = 12'h012;
  localparam logic [11:0] A_PERIOD  = 12'h013;

  logic        clk;
  logic        reset_n;
  logic [3:0]  buttons;
  logic [11:0] register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        press_pending;
  logic [15:0] rd;

  int err_cnt = 0;
  int chk_cnt = 0;

  button_controller #(
    .BASE_INDEX (12'h010)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .buttons              (buttons),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .press_pending        (press_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic reg_read(input logic [11:0] idx, output logic [15:0] data);
    @(negedge clk);
    register_index = idx;
    register_read  = 1'b1;
    @(negedge clk);
    register_read  = 1'b0;
    data = register_read_value;
  endtask

  task automatic reg_write(input logic [11:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index       = idx;
    register_write_value = val;
    register_write       = 1'b1;
    @(negedge clk);
    register_write       = 1'b0;
  endtask

  initial begin
    reset_n              = 1'b0;
    buttons              = 4'd0;
    register_index       = 12'd0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_write_value = 16'd0;
    #3;
    check_eq("rst_rdata", register_read_value, 16'd0);
    check_eq("rst_pend", {15'd0, press_pending}, 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Address decode and reset contents
    reg_read(A_PERIOD, rd);      check_eq("period_default", rd, 16'd50000);
    reg_read(12'h014, rd);       check_eq("decode_above", rd, 16'd0);
    reg_read(12'h00F, rd);       check_eq("decode_below", rd, 16'd0);
    reg_read(A_STATE, rd);       check_eq("state_reset", rd, 16'd0);

    // Clean press with PERIOD=4: stable flips on the 6th edge after the input change
    reg_write(A_PERIOD, 16'd4);
    reg_read(A_PERIOD, rd);      check_eq("period_wr4", rd, 16'd4);
    @(negedge clk);
    buttons[0]     = 1'b1;
    register_index = A_STATE;
    register_read  = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("press_state_early", register_read_value, 16'h0000);
    check_eq("press_pend_early", {15'd0, press_pending}, 16'd0);
    @(negedge clk);
    register_read = 1'b0;
    check_eq("press_state", register_read_value, 16'h0001);
    check_eq("press_pend", {15'd0, press_pending}, 16'd1);
    reg_read(A_PRESS, rd);       check_eq("press_latch", rd, 16'h0001);
    @(negedge clk);
    check_eq("pend_cleared", {15'd0, press_pending}, 16'd0);
    reg_read(A_PRESS, rd);       check_eq("press_cor", rd, 16'h0000);

    // Bounce: button1 toggles every 3 cycles with PERIOD=8, then settles high
    reg_write(A_PERIOD, 16'd8);
    for (int i = 0; i < 10; i++) begin
      buttons[1] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    buttons[1] = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("bounce_pend", {15'd0, press_pending}, 16'd1);
    reg_read(A_RELEASE, rd);     check_eq("bounce_release", rd, 16'h0000);

    // Clear-on-read race: read PRESS on the edge button2 becomes stable
    @(negedge clk);
    buttons[2] = 1'b1;
    repeat (8) @(negedge clk);
    reg_read(A_PRESS, rd);       check_eq("race_old", rd, 16'h0002);
    reg_read(A_PRESS, rd);       check_eq("race_new", rd, 16'h0004);

    // W1C with PRESS=0xF
    reg_write(A_PERIOD, 16'd4);
    buttons = 4'h0;
    repeat (10) @(negedge clk);
    buttons = 4'hF;
    repeat (10) @(negedge clk);
    reg_read(A_RELEASE, rd);     check_eq("release_all", rd, 16'h0007);
    reg_write(A_PRESS, 16'h0005);
    reg_read(A_PRESS, rd);       check_eq("w1c", rd, 16'h000A);
    reg_read(A_PRESS, rd);       check_eq("w1c_cor", rd, 16'h0000);

    // Ignored writes
    reg_write(A_STATE, 16'hFFFF);
    reg_read(A_STATE, rd);       check_eq("state_ro", rd, 16'h000F);
    reg_write(12'h014, 16'h1234);
    reg_write(12'h00F, 16'h4321);
    reg_read(A_PERIOD, rd);      check_eq("wr_outside", rd, 16'd4);

    // Simultaneous read and write of PERIOD, then read-data hold
    @(negedge clk);
    register_index       = A_PERIOD;
    register_write_value = 16'd7;
    register_read        = 1'b1;
    register_write       = 1'b1;
    @(negedge clk);
    register_read  = 1'b0;
    register_write = 1'b0;
    check_eq("rw_same_old", register_read_value, 16'd4);
    register_index = A_STATE;
    repeat (3) @(negedge clk);
    check_eq("rdata_hold", register_read_value, 16'd4);
    reg_read(A_PERIOD, rd);      check_eq("rw_same_new", rd, 16'd7);

    // PERIOD=0 still debounces (acts as 1)
    reg_write(A_PERIOD, 16'd0);
    buttons = 4'h7;
    repeat (6) @(negedge clk);
    reg_read(A_RELEASE, rd);     check_eq("period0_release", rd, 16'h0008);

    // Reset mid-debounce
    reg_write(A_PERIOD, 16'd8);
    buttons = 4'h0;
    repeat (12) @(negedge clk);
    buttons = 4'h1;
    repeat (12) @(negedge clk);
    reg_read(A_PERIOD, rd);      check_eq("pre_rst_period", rd, 16'd8);
    check_eq("pre_rst_pend", {15'd0, press_pending}, 16'd1);
    @(negedge clk);
    buttons[3] = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_rdata", register_read_value, 16'd0);
    check_eq("midrst_pend", {15'd0, press_pending}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    reg_read(A_STATE, rd);       check_eq("postrst_state", rd, 16'h0000);
    reg_read(A_PERIOD, rd);      check_eq("postrst_period", rd, 16'd50000);
    reg_write(A_PERIOD, 16'd4);
    repeat (10) @(negedge clk);
    reg_read(A_PRESS, rd);       check_eq("postrst_press", rd, 16'h0009);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/button_controller.md
BUTTON_CONTROLLER -- requirements
Module: button_controller

Interface
REQ-001 SHALL have parameter BASE_INDEX, default 12'd0: register index of the first of four registers.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 16'd50000: debounce period in clk cycles after reset (2 ms at 25 MHz).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state in this domain.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port buttons, input, 4 bits: raw asynchronous button levels; 1 means pressed.
REQ-006 SHALL have port register_index, input, 12 bits: CPU register index.
REQ-007 SHALL have port register_read, input, 1 bit: read strobe.
REQ-008 SHALL have port register_write, input, 1 bit: write strobe.
REQ-009 SHALL have port register_write_value, input, 16 bits: write data.
REQ-010 SHALL have port register_read_value, output, 16 bits: registered read data.
REQ-011 SHALL have port press_pending, output, 1 bit: registered OR of the PRESS latch bits.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-013 SHALL give each button a 16-bit counter: zeroed when the synchronized level equals the stable state, incremented otherwise; when it reaches max(PERIOD,1), stable toggles and the counter zeroes the same cycle.
REQ-014 SHALL make a stable 0->1 toggle set that button's PRESS bit and a stable 1->0 toggle set its RELEASE bit, in the cycle stable changes.
REQ-015 SHALL map registers: BASE+0 STATE (read-only, {12'd0,stable}); BASE+1 PRESS; BASE+2 RELEASE; BASE+3 PERIOD (read/write, 16 bits).
REQ-016 SHALL make PRESS and RELEASE sticky, cleared on read and by write-1-to-clear on bits [3:0]; upper bits read 0.
REQ-017 SHALL give a new event set priority over clear in the same cycle: next = (latch & ~clear) | new; the read returns the pre-clear latch.
REQ-018 SHALL register read data one cycle after the register_read strobe; reads of indices outside BASE..BASE+3 return 16'd0 so the top level can OR-combine peripherals.
REQ-019 SHALL hold register_read_value when register_read is low.
REQ-020 SHALL apply a PERIOD write the next cycle; counters are not reset, so a counter already >= the new period fires on its next increment.
REQ-021 SHALL ignore writes to STATE and to indices outside BASE..BASE+3.
REQ-022 SHALL, on simultaneous read and write to the same index, return pre-write contents and apply the write.
REQ-023 SHALL keep press_pending one cycle behind the PRESS latch.

Reset
REQ-024 SHALL, on reset_n low, immediately set synchronizers, stable state, counters, PRESS, RELEASE, register_read_value and press_pending to 0, and PERIOD to DEFAULT_PERIOD.
REQ-025 SHALL, if reset asserts mid-debounce, lose the pending transition; a held button then registers as a new PRESS after release.

Structure
REQ-026 SHALL place register offsets (0..3) and DEFAULT_PERIOD in a shared package/header button_defs used by the CPU-side software constants.
REQ-027 SHALL instantiate one sub-module, button_debounce (synchronizer, counter, stable flop, edge pulses), four times.

Verification
REQ-028 SHALL verify clean press: PERIOD=4, button0 0->1 held -> STATE=0x0001 at 2+4 cycles after the edge, PRESS=0x0001, press_pending=1 one cycle later.
REQ-029 SHALL verify bounce: PERIOD=8, button1 toggles every 3 cycles for 30 cycles then settles high -> exactly one PRESS bit1, no RELEASE.
REQ-030 SHALL verify clear-on-read race: read PRESS in the same cycle a new button2 press stabilizes -> read returns the old value, next read returns 0x0004.
REQ-031 SHALL verify W1C: PRESS=0x000F, write 0x0005 to BASE+1 -> PRESS=0x000A.
REQ-032 SHALL verify address decode: BASE_INDEX=12'h010, read index 0x014 -> 0x0000; read 0x013 after reset -> 50000.
REQ-033 SHALL verify reset mid-debounce: assert reset_n low at counter=3 -> all outputs 0 asynchronously; PERIOD reads DEFAULT_PERIOD.
